// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state enum, the NOP encoding and the halfword buffer geometry.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HALT
    } fetch_state_e;

    localparam logic [15:0] NOP_INSTR       = 16'hffff;
    localparam int          FETCH_BUF_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] instr;
    } hw_entry_t;

    // True when a word fetched for a PC with bit 1 = odd still fits
    // into the buffer on top of cnt entries.
    function automatic logic fits(input logic [2:0] cnt, input logic odd);
        logic [3:0] need;
        need = odd ? 4'd1 : 4'd2;
        return ({1'b0, cnt} + need) <= 4'(FETCH_BUF_DEPTH);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Halfword FIFO: push of 0/1/2 entries, pop of 1, flush, occupancy count.
// Ports: clk_i, rst_i, flush, push_cnt/push_a/push_b, pop, head, avail, count.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush,
    input  logic [1:0] push_cnt,
    input  hw_entry_t  push_a,
    input  hw_entry_t  push_b,
    input  logic       pop,
    output hw_entry_t  head,
    output logic       avail,
    output logic [2:0] count
);

    hw_entry_t  mem [FETCH_BUF_DEPTH];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;

    // An empty buffer exposes the entry being pushed this cycle, so a
    // returning word can reach the output register without an extra cycle.
    assign avail = (count != 3'd0) || (push_cnt != 2'd0);
    assign head  = (count != 3'd0) ? mem[rd_ptr] : push_a;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push_cnt != 2'd0)
                mem[wr_ptr] <= push_a;
            if (push_cnt == 2'd2)
                mem[wr_ptr + 2'd1] <= push_b;
            wr_ptr <= wr_ptr + push_cnt;
            rd_ptr <= rd_ptr + {1'b0, pop};
            count  <= count + {1'b0, push_cnt} - {2'b0, pop};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: word requests to imem, halfword buffer, registered output.
// Ports: clk_i/rst_i, stall/branch/halt controls, imem req/gnt/rvalid bus, instr/PC outputs.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_en_i,
    input  logic [31:0] branch_target_i,
    input  logic        halt_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [15:0] instr_o,
    output logic        instr_en_o,
    output logic [31:0] programm_counter_o,
    output logic [31:0] next_programm_counter_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  req_addr_q;
    logic [31:0]  req_pc_q;
    logic         discard_q;
    logic         orphan_q;

    logic         halting;
    logic         accept;
    logic         push_ok;
    logic         flush;
    logic         pop;
    logic         avail;
    logic [1:0]   push_cnt;
    logic [2:0]   count;
    logic [2:0]   cnt_after;
    hw_entry_t    push_a;
    hw_entry_t    push_b;
    hw_entry_t    head;

    assign halting = halt_i || (state_q == HALT);
    assign accept  = (state_q == WAIT) && imem_rvalid_i;
    assign push_ok = accept && !discard_q && !branch_en_i && !halt_i;
    assign flush   = branch_en_i || halting;
    assign pop     = avail && !stall_i && !flush;

    // A word fetched for an odd halfword PC only contributes its upper half.
    assign push_cnt     = push_ok ? (req_pc_q[1] ? 2'd1 : 2'd2) : 2'd0;
    assign push_a.pc    = req_pc_q;
    assign push_a.instr = req_pc_q[1] ? imem_rdata_i[31:16]
                                      : imem_rdata_i[15:0];
    assign push_b.pc    = req_pc_q + 32'd2;
    assign push_b.instr = imem_rdata_i[31:16];

    assign cnt_after = count + {1'b0, push_cnt} - {2'b0, pop};

    fetch_buffer u_buf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush    (flush),
        .push_cnt (push_cnt),
        .push_a   (push_a),
        .push_b   (push_b),
        .pop      (pop),
        .head     (head),
        .avail    (avail),
        .count    (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (!branch_en_i && !orphan_q &&
                    fits(count, fetch_pc_q[1]))
                    state_d = REQ;
            REQ:
                if (imem_gnt_i)
                    state_d = WAIT;
            WAIT:
                if (imem_rvalid_i)
                    state_d = (!branch_en_i &&
                               fits(cnt_after, fetch_pc_q[1])) ? REQ : IDLE;
            HALT:
                state_d = HALT;
            default:
                state_d = IDLE;
        endcase
        if (halt_i)
            state_d = HALT;
    end

    always_comb begin
        imem_req_o  = (state_q == REQ);
        imem_addr_o = req_addr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            req_addr_q <= 32'd0;
            req_pc_q   <= 32'd0;
            discard_q  <= 1'b0;
            // A granted transaction cut off by reset still returns a word;
            // hold new requests until it has gone by.
            orphan_q   <= (state_q == WAIT) ||
                          (state_q == REQ && imem_gnt_i) ||
                          (orphan_q && !imem_rvalid_i);
        end else begin
            if (imem_rvalid_i)
                orphan_q <= 1'b0;
            if (branch_en_i && !halting) begin
                fetch_pc_q <= branch_target_i & ~32'd1;
                discard_q  <= (state_q == REQ) ||
                              (state_q == WAIT && !imem_rvalid_i);
            end else begin
                if (state_q == REQ && imem_gnt_i && !discard_q)
                    fetch_pc_q <= req_addr_q + 32'd4;
                if (accept)
                    discard_q <= 1'b0;
            end
            // Address is frozen on entry to REQ so it stays stable until grant.
            if (state_d == REQ && state_q != REQ) begin
                req_addr_q <= {fetch_pc_q[31:2], 2'b00};
                req_pc_q   <= fetch_pc_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_o                 <= NOP_INSTR;
            instr_en_o              <= 1'b0;
            programm_counter_o      <= 32'd0;
            next_programm_counter_o <= 32'd0;
        end else if (flush) begin
            instr_o    <= NOP_INSTR;
            instr_en_o <= 1'b0;
        end else if (!stall_i) begin
            if (avail) begin
                instr_o                 <= head.instr;
                instr_en_o              <= 1'b1;
                programm_counter_o      <= head.pc;
                next_programm_counter_o <= head.pc + 32'd2;
            end else begin
                instr_o    <= NOP_INSTR;
                instr_en_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a simple imem responder.
// The responder grants immediately and returns data rv_delay cycles later.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        branch_en_i;
    logic [31:0] branch_target_i;
    logic        halt_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [15:0] instr_o;
    logic        instr_en_o;
    logic [31:0] programm_counter_o;
    logic [31:0] next_programm_counter_o;

    always #5 clk_i = ~clk_i;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .stall_i                 (stall_i),
        .branch_en_i             (branch_en_i),
        .branch_target_i         (branch_target_i),
        .halt_i                  (halt_i),
        .imem_req_o              (imem_req_o),
        .imem_addr_o             (imem_addr_o),
        .imem_gnt_i              (imem_gnt_i),
        .imem_rvalid_i           (imem_rvalid_i),
        .imem_rdata_i            (imem_rdata_i),
        .instr_o                 (instr_o),
        .instr_en_o              (instr_en_o),
        .programm_counter_o      (programm_counter_o),
        .next_programm_counter_o (next_programm_counter_o)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rv_delay = 0;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = 32'd0;
    int          gnt_cnt = 0;
    logic [31:0] last_gnt = 32'd0;
    logic [31:0] exp_pc = 32'd0;
    int          got = 0;

    assign imem_gnt_i = imem_req_o;

    function automatic logic [15:0] hw(input logic [31:0] p);
        if (p == 32'h0) return 16'h1111;
        if (p == 32'h2) return 16'h2222;
        return p[16:1] ^ 16'h3c3c;
    endfunction

    initial begin
        logic        g;
        logic [31:0] a;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        forever begin
            @(negedge clk_i);
            g = imem_req_o && imem_gnt_i;
            a = imem_addr_o;
            @(posedge clk_i);
            #1;
            if (g) begin
                pend     = 1'b1;
                pcnt     = rv_delay;
                paddr    = a;
                gnt_cnt  = gnt_cnt + 1;
                last_gnt = a;
            end
            if (pend && pcnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = {hw(paddr + 32'd2), hw(paddr)};
                pend          = 1'b0;
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = 32'hdead_beef;
                if (pend) pcnt = pcnt - 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_en"}, 32'(instr_en_o), 32'd1);
        chk({tag, "_pc"}, programm_counter_o, exp_pc);
        chk({tag, "_in"}, 32'(instr_o), 32'(hw(exp_pc)));
        chk({tag, "_np"}, next_programm_counter_o, exp_pc + 32'd2);
        exp_pc = exp_pc + 32'd2;
    endtask

    task automatic wait_out(input string tag);
        int k = 0;
        cyc();
        while (!instr_en_o && k < 40) begin
            cyc();
            k++;
        end
        chk_out(tag);
    endtask

    task automatic consume(input string tag);
        if (instr_en_o) begin
            chk_out(tag);
            got++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 32'(imem_req_o), 32'd0);
        chk({tag, "_addr"}, imem_addr_o, 32'd0);
        chk({tag, "_in"}, 32'(instr_o), 32'h0000ffff);
        chk({tag, "_en"}, 32'(instr_en_o), 32'd0);
        chk({tag, "_pc"}, programm_counter_o, 32'd0);
        chk({tag, "_np"}, next_programm_counter_o, 32'd0);
    endtask

    initial begin
        int          k;
        int          g0;
        int          req_seen;
        int          en_seen;
        logic        seen;
        logic [31:0] first_addr;

        rst_i           = 1'b1;
        stall_i         = 1'b0;
        branch_en_i     = 1'b0;
        branch_target_i = 32'd0;
        halt_i          = 1'b0;

        // reset and first two halfwords
        cyc();
        cyc();
        chk_reset("rst");
        rst_i = 1'b0;
        cyc();
        chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'd0);
        cyc();
        chk("lat_en", 32'(instr_en_o), 32'd0);
        cyc();
        exp_pc = 32'd0;
        chk_out("hw0");
        cyc();
        chk_out("hw2");

        // streaming then a 5-cycle stall
        for (int i = 0; i < 6; i++) begin
            cyc();
            consume("strm");
        end
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_en", 32'(instr_en_o), 32'd1);
            chk("stall_pc", programm_counter_o, exp_pc - 32'd2);
            chk("stall_in", 32'(instr_o), 32'(hw(exp_pc - 32'd2)));
        end
        chk("stall_req", 32'(imem_req_o), 32'd0);
        stall_i = 1'b0;
        got = 0;
        for (int i = 0; i < 24; i++) begin
            cyc();
            consume("rel");
        end
        chk("rel_rate", 32'(got >= 20), 32'd1);

        // branch to 0x106 with a response outstanding
        rv_delay = 3;
        k = 0;
        while (!pend && k < 20) begin
            cyc();
            consume("pre_br");
            k++;
        end
        chk("br_pend", 32'(pend), 32'd1);
        g0 = gnt_cnt;
        branch_en_i     = 1'b1;
        branch_target_i = 32'h0000_0106;
        cyc();
        branch_en_i = 1'b0;
        rv_delay    = 0;
        chk("br_en", 32'(instr_en_o), 32'd0);
        chk("br_in", 32'(instr_o), 32'h0000ffff);
        seen = 1'b0;
        first_addr = 32'hffff_ffff;
        k = 0;
        do begin
            cyc();
            if (!seen && gnt_cnt != g0) begin
                seen = 1'b1;
                first_addr = last_gnt;
            end
            k++;
        end while (!instr_en_o && k < 40);
        chk("br_addr", first_addr, 32'h0000_0104);
        exp_pc = 32'h0000_0106;
        chk_out("br_a");
        wait_out("br_b");

        // branch + stall in the same cycle as rvalid
        wait_out("s1");
        wait_out("s2");
        k = 0;
        while (!imem_rvalid_i && k < 20) begin
            cyc();
            k++;
        end
        chk("bs_rv", 32'(imem_rvalid_i), 32'd1);
        branch_en_i     = 1'b1;
        stall_i         = 1'b1;
        branch_target_i = 32'h0000_0201;
        cyc();
        branch_en_i = 1'b0;
        stall_i     = 1'b0;
        chk("bs_en", 32'(instr_en_o), 32'd0);
        chk("bs_in", 32'(instr_o), 32'h0000ffff);
        exp_pc = 32'h0000_0200;
        wait_out("bs_a");
        wait_out("bs_b");

        // halt while a response is pending
        rv_delay = 2;
        k = 0;
        while (!pend && k < 20) begin
            cyc();
            k++;
        end
        chk("h_pend", 32'(pend), 32'd1);
        halt_i = 1'b1;
        cyc();
        halt_i = 1'b0;
        chk("h_en", 32'(instr_en_o), 32'd0);
        g0 = gnt_cnt;
        req_seen = 0;
        en_seen  = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (imem_req_o) req_seen++;
            if (instr_en_o) en_seen++;
        end
        chk("h_req", 32'(req_seen), 32'd0);
        chk("h_ens", 32'(en_seen), 32'd0);
        chk("h_gnt", 32'(gnt_cnt), 32'(g0));

        // reset, then fetch across the top of the address space
        rst_i    = 1'b1;
        rv_delay = 0;
        cyc();
        cyc();
        chk_reset("rst2");
        rst_i = 1'b0;
        cyc();
        chk("rst2_first", 32'(imem_req_o), 32'd1);
        branch_en_i     = 1'b1;
        branch_target_i = 32'hffff_fffc;
        cyc();
        branch_en_i = 1'b0;
        exp_pc = 32'hffff_fffc;
        wait_out("wr_a");
        wait_out("wr_b");
        chk("wr_np0", next_programm_counter_o, 32'd0);
        wait_out("wr_c");
        chk("wr_addr", last_gnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
